simon_key_expander: RTL and testbench
=====================================

SIMON_KEY_EXPANDER -- requirements
Module: simon_key_expander

Interface
REQ-001 SHALL have parameter WW, default 32, meaning word width n; legal 32 or 64.
REQ-002 SHALL have parameter NKW, default 4, meaning key words m; legal 3,4 for WW=32 and 2,3,4 for WW=64.
REQ-003 SHALL have port clk, input, 1, clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port key_i, input, NKW*WW, master key; word j = key_i[j*WW +: WW], word 0 = k0.
REQ-006 SHALL have port key_vld_i / key_rdy_o, input / output, 1 each, key-load handshake.
REQ-007 SHALL have port rk_o, output, WW, current round key.
REQ-008 SHALL have port rk_vld_o / rk_rdy_i, output / input, 1 each, round-key handshake.
REQ-009 SHALL have port rk_last_o, output, 1; high with rk_vld_o on the final round key.
REQ-010 SHALL have port seq_rst_o, output, 1, drives rst_seqs_i of simon_seq_gen (mode_i tied 0).
REQ-011 SHALL have port seq_run_o, output, 1, drives run_en_i of simon_seq_gen.
REQ-012 SHALL have port seq_i, input, 1, z bit from simon_seq_gen seq_o.
REQ-013 SHALL have port busy_o, output, 1; high in any state other than IDLE.

Function
REQ-014 SHALL set round count T = 42 (32,3), 44 (32,4), 68 (64,2), 69 (64,3), 72 (64,4).
REQ-015 SHALL implement FSM IDLE -> SRST -> RUN -> IDLE.
REQ-016 IDLE: key_rdy_o=1. On key_vld_i&key_rdy_o: capture NKW words into window w[0..NKW-1], clear round counter, go to SRST.
REQ-017 SRST: hold for exactly one cycle with seq_rst_o=1 and seq_run_o=0, then go to RUN.
REQ-018 RUN: rk_vld_o=1, rk_o=w[0], rk_last_o=(counter==T-1), key_rdy_o=0.
REQ-019 On each RUN transfer (rk_vld_o&rk_rdy_i): shift w[j]<=w[j+1] and load w[NKW-1]<=new word; pulse seq_run_o=1 for that cycle only; increment the counter.
REQ-020 Define c = 2^WW-4 and ROR as rotate right within WW bits. Compute the new word as tmp=ROR(w[NKW-1],3); if NKW==4 then tmp^=w[1]; tmp^=ROR(tmp,1); new = w[0]^tmp^c^seq_i (seq_i in bit 0).
REQ-021 seq_i SHALL be sampled only in the transfer cycle; the generator then advances, so the k[m+i] computation uses z_i.
REQ-022 On the transfer with rk_last_o=1, go to IDLE; key_rdy_o=1 on the next cycle.
REQ-023 With rk_rdy_i=0, rk_o, rk_last_o, the window, the counter and seq_run_o SHALL hold; seq_run_o=0.
REQ-024 seq_rst_o and seq_run_o SHALL never be high in the same cycle.
REQ-025 Latency: key accepted at cycle N gives the first rk_vld_o=1 at N+2; with rk_rdy_i held at 1, T keys follow on consecutive cycles.
REQ-026 key_vld_i SHALL be ignored outside IDLE; a new key SHALL NOT corrupt a run in progress.

Reset
REQ-027 rst=1 SHALL force IDLE, counter=0 and window=0 at the next edge, from any state including mid-RUN.
REQ-028 Reset values: key_rdy_o=0 during rst (1 after release), rk_vld_o=0, rk_last_o=0, rk_o=0, seq_rst_o=0, seq_run_o=0, busy_o=0.

Configuration
REQ-029 Macro SIMON_KEXP_ABORT_EN defined: the module SHALL add port abort_i (input, 1). abort_i=1 in SRST or RUN SHALL go to IDLE at the next edge, drop rk_vld_o and discard the window. abort_i SHALL be ignored in IDLE.
REQ-030 Macro SIMON_KEXP_ABORT_EN undefined: port abort_i SHALL be absent, and only rst or completion SHALL leave RUN.

Verification
REQ-031 WW=32, NKW=4, key words 0x03020100, 0x0b0a0908, 0x13121110, 0x1b1a1918, rk_rdy_i=1 -> first four rk_o equal those words in order; 44 keys total; only the 44th has rk_last_o=1; all keys match the golden model; golden-model encryption of 0x656b696c20646e75 gives 0x44c8fc20b9dfa07a.
REQ-032 Same key with rk_rdy_i toggled pseudo-randomly -> key sequence identical to REQ-031; seq_run_o count equals 44 transfers; no stall-cycle pulses.
REQ-033 rst asserted after round 20 transfer -> next cycle IDLE, rk_vld_o=0; reload key -> full correct 44-key sequence.
REQ-034 key_vld_i held 1 throughout a run with a different key -> run unaffected; second key accepted only after rk_last_o transfer.
REQ-035 WW=64, NKW=2 golden vector (key 0x0f0e0d0c0b0a0908_0706050403020100) -> 68 keys match golden; rk_last_o on 68th.
REQ-036 With SIMON_KEXP_ABORT_EN, abort_i pulse in SRST and again at round 10 -> IDLE next cycle each time; subsequent load gives correct sequence.

Source files
------------

// File: rtl/simon_key_expander.sv
// Streams the SIMON round keys from a master key, with one round key per rk handshake.
// Defining SIMON_KEXP_ABORT_EN adds the abort_i port.
module simon_key_expander #(
   parameter int unsigned WW  = 32,
   parameter int unsigned NKW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NKW*WW-1:0] key_i,
   input  logic              key_vld_i,
   output logic              key_rdy_o,
   output logic [WW-1:0]     rk_o,
   output logic              rk_vld_o,
   input  logic              rk_rdy_i,
   output logic              rk_last_o,
   output logic              seq_rst_o,
   output logic              seq_run_o,
   input  logic              seq_i,
`ifdef SIMON_KEXP_ABORT_EN
   input  logic              abort_i,
`endif
   output logic              busy_o
);

   localparam int unsigned T  = (WW == 32) ? ((NKW == 3) ? 42 : 44)
                                           : ((NKW == 2) ? 68 : (NKW == 3) ? 69 : 72);
   localparam int unsigned CW = $clog2(T);
   localparam logic [WW-1:0] C = ~WW'(3);
   localparam logic USE_W1 = (NKW == 4);

   typedef enum logic [1:0] {IDLE, SRST, RUN} state_t;

   state_t                 state_q, state_d;
   logic [NKW-1:0][WW-1:0] w_q, w_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WW-1:0]          tmp_a, tmp_b, new_w;
   logic                   xfer, abort;

   function automatic logic [WW-1:0] ror(input logic [WW-1:0] x, input int unsigned r);
      return (x >> r) | (x << (WW - r));
   endfunction

   // Next key word from the current window and the z bit of this transfer
   always_comb begin
      tmp_a = ror(w_q[NKW-1], 3) ^ (USE_W1 ? w_q[1] : '0);
      tmp_b = tmp_a ^ ror(tmp_a, 1);
      new_w = w_q[0] ^ tmp_b ^ C ^ WW'(seq_i);
   end

`ifdef SIMON_KEXP_ABORT_EN
   assign abort = abort_i && (state_q != IDLE);
`else
   assign abort = 1'b0;
`endif

   assign xfer      = (state_q == RUN) && rk_rdy_i && !abort;
   assign key_rdy_o = (state_q == IDLE) && !rst;
   assign rk_vld_o  = (state_q == RUN);
   assign rk_o      = w_q[0];
   assign rk_last_o = (state_q == RUN) && (cnt_q == CW'(T - 1));
   assign seq_rst_o = (state_q == SRST);
   assign seq_run_o = xfer;
   assign busy_o    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (key_vld_i) begin
               w_d     = key_i;
               cnt_d   = '0;
               state_d = SRST;
            end
         end
         SRST: state_d = RUN;
         RUN: begin
            if (xfer) begin
               w_d   = {new_w, w_q[NKW-1:1]};
               cnt_d = cnt_q + CW'(1);
               if (rk_last_o) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort discards the window so no stale key material survives
      if (abort) begin
         state_d = IDLE;
         w_d     = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_simon_key_expander.sv
// Bench for simon_key_expander: (32,4) and (64,2) instances, z-sequence generator model,
// golden key-schedule model and scoreboard. Abort checks compile with SIMON_KEXP_ABORT_EN.
module tb_simon_key_expander;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] key_i = '0;
   logic         key_vld_i = 1'b0, key_rdy_o;
   logic [31:0]  rk_o;
   logic         rk_vld_o, rk_rdy_i = 1'b0, rk_last_o;
   logic         seq_rst_o, seq_run_o, seq_i, busy_o;
   logic         abort_i = 1'b0;

   logic [127:0] key64 = '0;
   logic         kv64 = 1'b0, kr64, rv64, rr64 = 1'b1, last64;
   logic [63:0]  rk64;
   logic         srst64, srun64, seq64, busy64;

   always #5 clk = ~clk;

   simon_key_expander #(.WW(32), .NKW(4)) dut (
      .clk(clk), .rst(rst), .key_i(key_i), .key_vld_i(key_vld_i), .key_rdy_o(key_rdy_o),
      .rk_o(rk_o), .rk_vld_o(rk_vld_o), .rk_rdy_i(rk_rdy_i), .rk_last_o(rk_last_o),
      .seq_rst_o(seq_rst_o), .seq_run_o(seq_run_o), .seq_i(seq_i),
`ifdef SIMON_KEXP_ABORT_EN
      .abort_i(abort_i),
`endif
      .busy_o(busy_o));

   simon_key_expander #(.WW(64), .NKW(2)) dut64 (
      .clk(clk), .rst(rst), .key_i(key64), .key_vld_i(kv64), .key_rdy_o(kr64),
      .rk_o(rk64), .rk_vld_o(rv64), .rk_rdy_i(rr64), .rk_last_o(last64),
      .seq_rst_o(srst64), .seq_run_o(srun64), .seq_i(seq64),
`ifdef SIMON_KEXP_ABORT_EN
      .abort_i(1'b0),
`endif
      .busy_o(busy64));

   logic [61:0] z2c = 62'b10101111011100000011010010011000101000010001111110010110110011;
   logic [61:0] z3c = 62'b11011011101011000110010111100000010010001010011100110100001111;

   // z-sequence generators, element 0 is the leftmost bit of the constant
   logic [5:0] zi32 = '0, zi64 = '0;
   always @(posedge clk) begin
      if (seq_rst_o) zi32 <= '0;
      else if (seq_run_o) zi32 <= (zi32 == 6'd61) ? 6'd0 : zi32 + 6'd1;
      if (srst64) zi64 <= '0;
      else if (srun64) zi64 <= (zi64 == 6'd61) ? 6'd0 : zi64 + 6'd1;
   end
   assign seq_i = z3c[6'd61 - zi32];
   assign seq64 = z2c[6'd61 - zi64];

   typedef struct {
      logic [127:0] key;
      logic [127:0] other;
      int           rdy_pct;
      int           stop_at;
      int           stop_kind;
      bit           hold;
      logic [31:0]  exp_rk0;
      int           exp_n;
   } vec_t;

   typedef struct {
      logic [63:0] rk;
      logic        last;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] ks[80];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] wmask(input int ww);
      return (ww == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
   endfunction

   function automatic logic [63:0] rorw(input logic [63:0] x, input int r, input int ww);
      return ((x >> r) | (x << (ww - r))) & wmask(ww);
   endfunction

   task automatic expand(input int ww, input int m, input logic [127:0] key, input int t,
                         input logic [61:0] z);
      logic [63:0] tmp, c;
      c = wmask(ww) ^ 64'd3;
      for (int j = 0; j < m; j++) ks[j] = 64'(key >> (j * ww)) & wmask(ww);
      for (int i = 0; i < t - m; i++) begin
         tmp = rorw(ks[i+m-1], 3, ww);
         if (m == 4) tmp = tmp ^ ks[i+1];
         tmp = tmp ^ rorw(tmp, 1, ww);
         ks[i+m] = ks[i] ^ tmp ^ c ^ 64'(z[61 - (i % 62)]);
      end
   endtask

   function automatic logic [127:0] encrypt(input int ww, input int t, input logic [127:0] pt);
      logic [63:0] x, y, tx;
      x = 64'(pt >> ww) & wmask(ww);
      y = pt[63:0] & wmask(ww);
      for (int r = 0; r < t; r++) begin
         tx = x;
         x  = y ^ (rorw(x, ww - 1, ww) & rorw(x, ww - 8, ww)) ^ rorw(x, ww - 2, ww) ^ ks[r];
         y  = tx;
      end
      return (128'(x) << ww) | 128'(y);
   endfunction

   task automatic load_key(input logic [127:0] k);
      int cyc = 0;
      @(negedge clk);
      while (!key_rdy_o && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("key_rdy_wait", 128'(key_rdy_o), 128'(1));
      key_i     = k;
      key_vld_i = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_key(input vec_t v);
      int   n = 0, pulses = 0, cyc = 0;
      bit   done = 0;
      exp_t e;
      expand(32, 4, v.key, 44, z3c);
      sbq.delete();
      for (int i = 0; i < 44; i++) sbq.push_back('{rk: ks[i], last: (i == 43)});
      load_key(v.key);
      if (v.hold) key_i = v.other;
      else key_vld_i = 1'b0;
      rk_rdy_i = ($urandom_range(99, 0) < v.rdy_pct);
      @(negedge clk);
      chk("srst_state", 128'({seq_rst_o, seq_run_o, rk_vld_o, busy_o, key_rdy_o}), 128'(5'b10010));
      while (!done && cyc < 1000) begin
         @(posedge clk);
         #1;
         rk_rdy_i = ($urandom_range(99, 0) < v.rdy_pct);
         @(negedge clk);
         cyc++;
         chk("run_state", 128'({rk_vld_o, key_rdy_o, busy_o, seq_rst_o}), 128'(4'b1010));
         chk("seq_run", 128'(seq_run_o), 128'(rk_rdy_i));
         pulses += int'(seq_run_o);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow act=extra_key exp=none @%0t", $time);
            done = 1;
         end else begin
            e = sbq[0];
            chk("rk", 128'(rk_o), 128'(e.rk[31:0]));
            chk("rk_last", 128'(rk_last_o), 128'(e.last));
            if (rk_rdy_i) begin
               if (n == 0) chk("rk_first", 128'(rk_o), 128'(v.exp_rk0));
               void'(sbq.pop_front());
               n++;
               if (rk_last_o || n == v.stop_at) done = 1;
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL run_timeout act=%0d exp=%0d", n, v.exp_n);
      end
      chk("xfer_count", 128'(n), 128'(v.exp_n));
      if (v.stop_kind == 1) begin
         @(posedge clk);
         #1;
         rst = 1'b1;
         rk_rdy_i = 1'b0;
         @(negedge clk);
         chk("rst_key_rdy", 128'(key_rdy_o), 128'(0));
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         chk("rst_state", 128'({rk_vld_o, rk_last_o, busy_o, seq_rst_o, seq_run_o, key_rdy_o, rk_o}),
             128'({6'b000001, 32'h0}));
`ifdef SIMON_KEXP_ABORT_EN
      end else if (v.stop_kind == 2) begin
         @(posedge clk);
         #1;
         abort_i  = 1'b1;
         rk_rdy_i = 1'b0;
         @(posedge clk);
         #1;
         abort_i = 1'b0;
         @(negedge clk);
         chk("abort_run", 128'({rk_vld_o, busy_o, key_rdy_o, rk_o}), 128'({3'b001, 32'h0}));
`endif
      end else begin
         chk("run_pulses", 128'(pulses), 128'(v.exp_n));
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("idle_after", 128'({key_rdy_o, rk_vld_o, busy_o}), 128'(3'b100));
         key_vld_i = 1'b0;
      end
   endtask

   vec_t         tbl[6];
   logic [127:0] k1, k2, k64;

   initial begin
      exp_t e;
      k1  = 128'h1b1a1918_13121110_0b0a0908_03020100;
      k2  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      k64 = 128'h0f0e0d0c0b0a0908_0706050403020100;
      tbl[0] = '{key: k1, other: '0, rdy_pct: 100, stop_at: 0,  stop_kind: 0, hold: 0, exp_rk0: 32'h03020100, exp_n: 44};
      tbl[1] = '{key: k1, other: '0, rdy_pct: 45,  stop_at: 0,  stop_kind: 0, hold: 0, exp_rk0: 32'h03020100, exp_n: 44};
      tbl[2] = '{key: k1, other: '0, rdy_pct: 100, stop_at: 20, stop_kind: 1, hold: 0, exp_rk0: 32'h03020100, exp_n: 20};
      tbl[3] = '{key: k1, other: '0, rdy_pct: 100, stop_at: 0,  stop_kind: 0, hold: 0, exp_rk0: 32'h03020100, exp_n: 44};
      tbl[4] = '{key: k1, other: k2, rdy_pct: 60,  stop_at: 0,  stop_kind: 0, hold: 1, exp_rk0: 32'h03020100, exp_n: 44};
      tbl[5] = '{key: k2, other: '0, rdy_pct: 80,  stop_at: 0,  stop_kind: 0, hold: 0, exp_rk0: 32'hcafef00d, exp_n: 44};

      expand(32, 4, k1, 44, z3c);
      chk("enc32_golden", encrypt(32, 44, 128'h656b696c20646e75), 128'h44c8fc20b9dfa07a);
      expand(64, 2, k64, 68, z2c);
      chk("enc64_golden", encrypt(64, 68, 128'h63736564207372656c6c657661727420),
          128'h49681b1e1e54fe3f65aa832af84e0bbc);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 128'({key_rdy_o, rk_vld_o, rk_last_o, seq_rst_o, seq_run_o, busy_o, rk_o}), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_release", 128'({key_rdy_o, rk_vld_o, busy_o, kr64}), 128'(4'b1001));

      for (int t = 0; t < 6; t++) run_key(tbl[t]);

      // 64-bit words, two key words, consumer always ready
      expand(64, 2, k64, 68, z2c);
      sbq.delete();
      for (int i = 0; i < 68; i++) sbq.push_back('{rk: ks[i], last: (i == 67)});
      key64 = k64;
      kv64  = 1'b1;
      @(posedge clk);
      #1;
      kv64 = 1'b0;
      @(negedge clk);
      chk("srst64", 128'({srst64, rv64, busy64}), 128'(3'b101));
      for (int i = 0; i < 68; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         chk("rk64_vld", 128'(rv64), 128'(1));
         chk("rk64", 128'(rk64), 128'(e.rk));
         chk("rk64_last", 128'(last64), 128'(e.last));
         if (i == 0) chk("rk64_first", 128'(rk64), 128'(64'h0706050403020100));
      end
      @(negedge clk);
      chk("idle64", 128'({kr64, rv64, busy64}), 128'(3'b100));

`ifdef SIMON_KEXP_ABORT_EN
      load_key(k1);
      key_vld_i = 1'b0;
      abort_i   = 1'b1;
      @(negedge clk);
      chk("abort_in_srst", 128'(seq_rst_o), 128'(1));
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      @(negedge clk);
      chk("abort_srst", 128'({rk_vld_o, busy_o, key_rdy_o}), 128'(3'b001));
      run_key('{key: k1, other: '0, rdy_pct: 100, stop_at: 10, stop_kind: 2, hold: 0, exp_rk0: 32'h03020100, exp_n: 10});
      run_key(tbl[0]);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
